// File: rtl/servo_seq_if.sv
// servo_seq control/table bus: control side drives commands and table writes,
// sequencer returns position and status.
interface servo_seq_if;
  logic       start;
  logic       stop;
  logic       loop;
  logic [2:0] len;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_pos;
  logic [7:0] wr_dwell;
  logic [7:0] pos;
  logic       busy;
  logic       done;
  logic [2:0] idx;

  modport master (
    output start, stop, loop, len,
    output wr_en, wr_addr, wr_pos, wr_dwell,
    input  pos, busy, done, idx
  );

  modport slave (
    input  start, stop, loop, len,
    input  wr_en, wr_addr, wr_pos, wr_dwell,
    output pos, busy, done, idx
  );
endinterface

// File: rtl/servo_seq.sv
// Waypoint sequencer feeding a servo PWM position; 8-entry (pos, dwell) table.
// SERVO_SEQ_SLEW_EN: rate-limited slewing; undefined: jump straight to target.
module servo_seq #(
  parameter int         TICK_CYCLES = 120000,
  parameter logic [7:0] HOME        = 8'd128
) (
  input logic        clk,
  input logic        rst,
  servo_seq_if.slave bus
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SLEW, DWELL, NEXT
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    pos_q;
  logic          busy_q;
  logic          done_q;
  logic [2:0]    idx_q;
  logic [2:0]    len_q;
  logic          loop_q;
  logic [7:0]    target;
  logic [7:0]    dwell_ld;
  logic [7:0]    dwell_cnt;
  logic [15:0]   tbl [8];

  assign tick     = (presc == PW'(TICK_CYCLES - 1));
  assign bus.pos  = pos_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.idx  = idx_q;

  // Table is not reset; writes are only honoured while idle.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q)
      tbl[bus.wr_addr] <= {bus.wr_pos, bus.wr_dwell};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      pos_q     <= HOME;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= 3'd0;
      len_q     <= 3'd0;
      loop_q    <= 1'b0;
      target    <= HOME;
      dwell_ld  <= 8'd0;
      dwell_cnt <= 8'd0;
    end else begin
      done_q <= 1'b0;
      presc  <= tick ? '0 : presc + 1'b1;
      if (state == IDLE) begin
        presc <= '0;
        if (bus.start && !bus.stop) begin
          len_q  <= bus.len;
          loop_q <= bus.loop;
          idx_q  <= 3'd0;
          busy_q <= 1'b1;
          state  <= LOAD;
        end
      end else if (bus.stop) begin
        presc  <= '0;
        busy_q <= 1'b0;
        state  <= IDLE;
      end else begin
        unique case (state)
          LOAD: begin
            target   <= tbl[idx_q][15:8];
            dwell_ld <= tbl[idx_q][7:0];
            presc    <= '0;
            state    <= SLEW;
          end
          SLEW: begin
            if (pos_q == target) begin
              dwell_cnt <= dwell_ld;
              presc     <= '0;
              state     <= DWELL;
            end else begin
`ifdef SERVO_SEQ_SLEW_EN
              if (tick)
                pos_q <= (pos_q < target) ? pos_q + 8'd1
                                          : pos_q - 8'd1;
`else
              pos_q <= target;
`endif
            end
          end
          DWELL: begin
            if (dwell_cnt == 8'd0) begin
              presc <= '0;
              state <= NEXT;
            end else if (tick) begin
              dwell_cnt <= dwell_cnt - 8'd1;
            end
          end
          NEXT: begin
            presc <= '0;
            if (idx_q < len_q) begin
              idx_q <= idx_q + 3'd1;
              state <= LOAD;
            end else if (loop_q) begin
              idx_q <= 3'd0;
              state <= LOAD;
            end else begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
